// File: rtl/alu_pipe.sv
// alu_pipe: single-stage pipelined ALU with a valid/ready handshake on both
// sides and a stored flag register (psr).
//
// An operation offered on a/b/opcode is accepted when in_valid && in_ready.
// Its result shows up on c/flags/out_wen with out_valid=1 one cycle later.
// The result is held there until the consumer takes it with out_ready.
// psr loads the operation's flags on the same edge that accepts it, so a
// following ADDC sees the carry immediately, with no bubble.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation offered on a, b, opcode
//   in_ready   block takes the offered operation this cycle
//   a, b       WIDTH-bit operands (b also carries the shift amount and imm[3:0])
//   opcode     8-bit operation encoding
//   out_valid  c/flags/out_wen hold a result
//   out_ready  consumer takes the result this cycle
//   c          WIDTH-bit result
//   flags      {Z, C, F(overflow), N, L} of the presented result
//   out_wen    register-write qualifier for c
//   psr        stored flag register, same ZCFNL layout
module alu_pipe #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [7:0]       opcode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] c,
   output logic [4:0]       flags,
   output logic             out_wen,
   output logic [4:0]       psr
);

   // Decoded operation kind. Immediate forms map onto their register
   // counterparts and only differ in how the B operand is built.
   typedef enum logic [3:0] {
      OpUndef, OpAnd, OpOr, OpXor, OpNot, OpAdd, OpAddu, OpAddc,
      OpAddcu, OpSub, OpCmp, OpCmpu, OpLsh, OpLsh1, OpRsh, OpArsh
   } opKind_e;

   localparam logic [WIDTH-1:0] ShiftLimit = WIDTH'(WIDTH);

   opKind_e          opKind;
   logic             useImm;
   logic             immZero;
   logic [7:0]       imm8;
   logic [WIDTH-1:0] opB;
   logic             carryIn;
   logic [WIDTH:0]   sumWide;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic             addOvf;
   logic             subOvf;
   logic             bigShift;
   logic             accept;

   logic [WIDTH-1:0] result_d, result_q;
   logic [4:0]       flags_d, flags_q;
   logic             outWen_d, outWen_q;
   logic             outValid_d, outValid_q;
   logic [4:0]       psr_d, psr_q;
   logic             defined;
   logic             zF, cF, fF, nF, lF;
   logic             zFromResult;

   // The input side is free whenever the output register is empty or is
   // being emptied this very cycle, which gives full throughput with a
   // single register stage.
   assign in_ready = !outValid_q || out_ready;
   assign accept   = in_valid && in_ready;

   // Opcode decode. Anything not matched stays OpUndef, which produces an
   // all-zero, non-writing result and leaves psr alone.
   always_comb begin
      opKind  = OpUndef;
      useImm  = 1'b0;
      immZero = 1'b0;
      case (opcode[7:4])
         4'h0: begin
            case (opcode[3:0])
               4'h1:    opKind = OpAnd;
               4'h2:    opKind = OpOr;
               4'h3:    opKind = OpXor;
               4'h4:    opKind = OpNot;
               4'h5:    opKind = OpAdd;
               4'h6:    opKind = OpAddu;
               4'h7:    opKind = OpAddc;
               4'h8:    opKind = OpAddcu;
               4'h9:    opKind = OpSub;
               4'hB:    opKind = OpCmp;
               4'hF:    opKind = OpCmpu;
               default: opKind = OpUndef;
            endcase
         end
         4'h5: begin opKind = OpAdd;  useImm = 1'b1; end
         4'h6: begin opKind = OpAddu; useImm = 1'b1; immZero = 1'b1; end
         4'h7: begin opKind = OpAddc; useImm = 1'b1; end
         4'h9: begin opKind = OpSub;  useImm = 1'b1; end
         4'hB: begin opKind = OpCmp;  useImm = 1'b1; end
         4'h8: begin
            case (opcode[3:0])
               4'h0, 4'h1: opKind = OpLsh;
               4'h4:       opKind = OpLsh1;
               4'h2:       opKind = OpRsh;
               4'h3:       opKind = OpArsh;
               default:    opKind = OpUndef;
            endcase
         end
         default: opKind = OpUndef;
      endcase
   end

   // Operand preparation and the shared adder/subtractor. The 8-bit
   // immediate is the opcode's low nibble glued to b[3:0]; only ADDUI
   // zero-extends it. Carry-in comes from psr as it stands right now,
   // i.e. before this accept edge updates it.
   always_comb begin
      imm8     = {opcode[3:0], b[3:0]};
      opB      = b;
      if (useImm) begin
         opB = immZero ? WIDTH'(imm8) : WIDTH'($signed(imm8));
      end
      carryIn  = ((opKind == OpAddc) || (opKind == OpAddcu)) ? psr_q[3] : 1'b0;
      sumWide  = {1'b0, a} + {1'b0, opB} + {{WIDTH{1'b0}}, carryIn};
      sum      = sumWide[WIDTH-1:0];
      diff     = a - opB;
      addOvf   = (a[WIDTH-1] == opB[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      subOvf   = (a[WIDTH-1] != opB[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      bigShift = (b >= ShiftLimit);
   end

   // Result and flag selection. Z follows the result for everything except
   // the compares, which report equality of the operands instead and never
   // write c.
   always_comb begin
      result_d    = '0;
      outWen_d    = 1'b1;
      defined     = 1'b1;
      zFromResult = 1'b1;
      zF          = 1'b0;
      cF          = 1'b0;
      fF          = 1'b0;
      nF          = 1'b0;
      lF          = 1'b0;
      case (opKind)
         OpAnd:   result_d = a & opB;
         OpOr:    result_d = a | opB;
         OpXor:   result_d = a ^ opB;
         OpNot:   result_d = ~a;
         OpAdd: begin
            result_d = sum;
            fF       = addOvf;
         end
         OpAddu, OpAddcu: begin
            result_d = sum;
            cF       = sumWide[WIDTH];
         end
         OpAddc: begin
            result_d = sum;
            cF       = sumWide[WIDTH];
            fF       = addOvf;
         end
         OpSub: begin
            result_d = diff;
            fF       = subOvf;
         end
         OpCmp: begin
            outWen_d    = 1'b0;
            zFromResult = 1'b0;
            zF          = (a == opB);
            nF          = ($signed(a) < $signed(opB));
         end
         OpCmpu: begin
            outWen_d    = 1'b0;
            zFromResult = 1'b0;
            zF          = (a == opB);
            lF          = (a < opB);
         end
         OpLsh:   result_d = bigShift ? '0 : (a << b);
         OpLsh1:  result_d = a << 1;
         OpRsh:   result_d = bigShift ? '0 : (a >> b);
         OpArsh:  result_d = bigShift ? {WIDTH{a[WIDTH-1]}} : $unsigned($signed(a) >>> b);
         default: begin
            outWen_d    = 1'b0;
            defined     = 1'b0;
            zFromResult = 1'b0;
         end
      endcase
      if (zFromResult) begin
         zF = (result_d == '0);
      end
      flags_d = {zF, cF, fF, nF, lF};
   end

   // Next-state for the handshake and psr. psr only moves on an accept, so a
   // stalled result can never update it a second time.
   always_comb begin
      outValid_d = outValid_q;
      psr_d      = psr_q;
      if (accept) begin
         outValid_d = 1'b1;
         if (defined) begin
            psr_d = flags_d;
         end
      end else if (out_ready) begin
         outValid_d = 1'b0;
      end
   end

   // Output register and psr. The result fields load only on accept so they
   // stay frozen while the consumer stalls; reset drops any pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outValid_q <= 1'b0;
         result_q   <= '0;
         flags_q    <= '0;
         outWen_q   <= 1'b0;
         psr_q      <= '0;
      end else begin
         outValid_q <= outValid_d;
         psr_q      <= psr_d;
         if (accept) begin
            result_q <= result_d;
            flags_q  <= flags_d;
            outWen_q <= outWen_d;
         end
      end
   end

   assign out_valid = outValid_q;
   assign c         = result_q;
   assign flags     = flags_q;
   assign out_wen   = outWen_q;
   assign psr       = psr_q;

endmodule

// File: doc/alu_pipe.md
ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter: WIDTH, 16, datapath width in bits; legal range 8..64.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: rst_n  input  1  asynchronous, active-low reset; reset is asynchronous and active-low, one clock domain.
REQ-004 Port: in_valid  input  1  an operation is offered on a, b and opcode.
REQ-005 Port: in_ready  output  1  the block accepts the offered operation this cycle.
REQ-006 Port: a, b  input  WIDTH each  operands.
REQ-007 Port: opcode  input  8  operation encoding, per REQ-013.
REQ-008 Port: out_valid  output  1  c, flags and out_wen hold a result.
REQ-009 Port: out_ready  input  1  the consumer takes the result this cycle.
REQ-010 Port: c, flags, out_wen  output  WIDTH / 5 / 1  result, flags ZCFNL (4=Z, 3=C, 2=F overflow, 1=N, 0=L), and the register-write qualifier.
REQ-011 Port: psr  output  5  stored flag register, ZCFNL layout.

Function
REQ-012 The block SHALL accept an operation on any clk edge where in_valid && in_ready, and SHALL present its result with out_valid=1 on the next cycle (latency 1).
REQ-013 Decode SHALL be as follows:
- opcode[7:4]=0000, opcode[3:0]: 1 AND, 2 OR, 3 XOR, 4 NOT(a), 5 ADD, 6 ADDU, 7 ADDC, 8 ADDCU, 9 SUB, B CMP, F CMPU.
- opcode[7:4]=0101 ADDI, 0110 ADDUI, 0111 ADDCI, 1001 SUBI, 1011 CMPI.
- opcode[7:4]=1000, opcode[3:0]: 0000/0001 LSHI (a<<b), 0100 LSH (a<<1), 0010 RSH (logical a>>b), 0011 ARSH (arithmetic a>>>b).
- Every other code is undefined.
REQ-014 For immediate ops, the B operand SHALL be {opcode[3:0],b[3:0]} extended to WIDTH. ADDUI zero-extends it; all other immediate ops sign-extend it.
REQ-015 Arithmetic SHALL be modulo 2^WIDTH. Carry-in for ADDC, ADDCU and ADDCI SHALL be psr[3] as it stands at the accept edge.
REQ-016 Flags SHALL be set as follows; every bit not listed is 0:
- logic ops and shifts: Z.
- ADD, ADDI: Z and F (signed overflow).
- ADDU, ADDUI: Z and C (carry-out).
- ADDC, ADDCI: Z, C and F.
- ADDCU: Z and C.
- SUB, SUBI: Z and F (overflow of a-b).
- CMP, CMPI: Z=(a==B), N=(signed a<B).
- CMPU: Z=(a==b), L=(unsigned a<b).
REQ-017 CMP, CMPU and CMPI SHALL output c=0 and out_wen=0. All other defined ops SHALL output out_wen=1.
REQ-018 psr SHALL load the op's flags at the accept edge for every defined op. Undefined ops SHALL output c=0, flags=0, out_wen=0, and SHALL leave psr unchanged.
REQ-019 For shifts, the amount SHALL be b taken as unsigned. An amount >= WIDTH SHALL give 0 for LSHI and RSH, and WIDTH copies of a[WIDTH-1] for ARSH.
REQ-020 Handshake: in_ready SHALL equal !out_valid || out_ready, computed combinationally.
REQ-021 While out_valid && !out_ready, c, flags and out_wen SHALL stay stable.
REQ-022 out_valid SHALL clear on a handshake with no new accept in the same cycle.
REQ-023 A simultaneous output handshake and input accept SHALL replace the result in one cycle with no bubble and no loss.
REQ-024 An operation SHALL affect psr exactly once regardless of how long it stalls. Back-to-back ADDC SHALL chain the carry without a bubble.

Reset
REQ-025 While rst_n=0, regardless of clk, the block SHALL drive out_valid=0, c=0, flags=0, out_wen=0, psr=0, in_ready=1.
REQ-026 Reset asserted mid-operation or mid-stall SHALL discard the pending result and SHALL NOT update psr.
REQ-027 The first accept SHALL be possible on the first rising clk edge after rst_n rises.

Verification (WIDTH=16)
REQ-028 ADDU a=FFFF b=0001 -> c=0000, flags=11000, psr=11000. Then ADDC a=0001 b=0001 -> c=0003, flags=00000.
REQ-029 ADD a=7FFF b=0001 -> c=8000, flags=00100, out_wen=1.
REQ-030 CMP a=FFFE b=0001 -> c=0, out_wen=0, flags=00010. CMPU with the same operands -> flags=00000.
REQ-031 ARSH a=8000 b=3 -> c=F000. LSHI a=00FF b=16 -> c=0000, flags=10000. ADDI a=0005 opcode=0101_1111 b=xxxE -> c=0003 (imm=-2).
REQ-032 Hold out_ready=0 for 3 cycles with 2 ops offered -> in_ready=0, first result stable. Raise out_ready -> second op accepted the same cycle; exactly 2 results, psr updated twice.
REQ-033 Pull rst_n low between clk edges while a result is stalled -> immediate out_valid=0, psr=00000. Accept on the first edge after release -> correct result.
